inst_item_encoder: RTL and testbench

- Converts decoded instruction items (instruction_t plus rs1/rs2/rd/imm fields) back into 32-bit RV32I machine words.
- Serves as the stimulus path for the core testbench: a sequencer pushes instruction items, and the encoder streams words to the instruction-memory model or fetch port.
- Validates operand ranges, flags unencodable items, and buffers results in an output FIFO so that fetch-side backpressure does not stall encoding.

---
 rtl/inst_item_encoder_pkg.sv | 143 ++++++++++++++
 rtl/inst_item_encoder_sync_fifo.sv | 44 ++++
 rtl/inst_item_encoder.sv | 59 +++++
 tb/tb_inst_item_encoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_item_encoder_pkg.sv
// Shared RV32I instruction item types, opcode/funct tables and the item encoder.
// Latency: purely combinational helpers.
// Backpressure: none; used by the encoder top and by any scoreboard.
package inst_item_encoder_pkg;

  localparam int WORD_SIZE = 32;

  typedef logic [4:0]           reg_t;
  typedef logic [WORD_SIZE-1:0] data_t;

  typedef enum logic [6:0] {
    NO_INST = 7'd0,
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
    SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK,
    CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
  } instruction_t;

  // Base opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Encoding format: selects operand layout and immediate range rule.
  typedef enum logic [3:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_SYS
  } fmt_t;

  typedef struct packed {
    fmt_t       fmt;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } op_info_t;

  // Per-instruction format/opcode/funct lookup; unknown values map to FMT_NONE.
  function automatic op_info_t op_info(input logic [6:0] inst);
    op_info_t oi;
    oi = '{fmt: FMT_NONE, opcode: 7'd0, funct3: 3'd0, funct7: F7_ZERO};
    case (inst)
      LUI:    oi = '{FMT_U,   OPC_LUI,    3'd0, F7_ZERO};
      AUIPC:  oi = '{FMT_U,   OPC_AUIPC,  3'd0, F7_ZERO};
      JAL:    oi = '{FMT_J,   OPC_JAL,    3'd0, F7_ZERO};
      JALR:   oi = '{FMT_I,   OPC_JALR,   3'd0, F7_ZERO};
      BEQ:    oi = '{FMT_B,   OPC_BRANCH, 3'd0, F7_ZERO};
      BNE:    oi = '{FMT_B,   OPC_BRANCH, 3'd1, F7_ZERO};
      BLT:    oi = '{FMT_B,   OPC_BRANCH, 3'd4, F7_ZERO};
      BGE:    oi = '{FMT_B,   OPC_BRANCH, 3'd5, F7_ZERO};
      BLTU:   oi = '{FMT_B,   OPC_BRANCH, 3'd6, F7_ZERO};
      BGEU:   oi = '{FMT_B,   OPC_BRANCH, 3'd7, F7_ZERO};
      LB:     oi = '{FMT_I,   OPC_LOAD,   3'd0, F7_ZERO};
      LH:     oi = '{FMT_I,   OPC_LOAD,   3'd1, F7_ZERO};
      LW:     oi = '{FMT_I,   OPC_LOAD,   3'd2, F7_ZERO};
      LBU:    oi = '{FMT_I,   OPC_LOAD,   3'd4, F7_ZERO};
      LHU:    oi = '{FMT_I,   OPC_LOAD,   3'd5, F7_ZERO};
      SB:     oi = '{FMT_S,   OPC_STORE,  3'd0, F7_ZERO};
      SH:     oi = '{FMT_S,   OPC_STORE,  3'd1, F7_ZERO};
      SW:     oi = '{FMT_S,   OPC_STORE,  3'd2, F7_ZERO};
      ADDI:   oi = '{FMT_I,   OPC_OP_IMM, 3'd0, F7_ZERO};
      SLTI:   oi = '{FMT_I,   OPC_OP_IMM, 3'd2, F7_ZERO};
      SLTIU:  oi = '{FMT_I,   OPC_OP_IMM, 3'd3, F7_ZERO};
      XORI:   oi = '{FMT_I,   OPC_OP_IMM, 3'd4, F7_ZERO};
      ORI:    oi = '{FMT_I,   OPC_OP_IMM, 3'd6, F7_ZERO};
      ANDI:   oi = '{FMT_I,   OPC_OP_IMM, 3'd7, F7_ZERO};
      SLLI:   oi = '{FMT_SH,  OPC_OP_IMM, 3'd1, F7_ZERO};
      SRLI:   oi = '{FMT_SH,  OPC_OP_IMM, 3'd5, F7_ZERO};
      SRAI:   oi = '{FMT_SH,  OPC_OP_IMM, 3'd5, F7_ALT};
      ADD:    oi = '{FMT_R,   OPC_OP,     3'd0, F7_ZERO};
      SUB:    oi = '{FMT_R,   OPC_OP,     3'd0, F7_ALT};
      SLL:    oi = '{FMT_R,   OPC_OP,     3'd1, F7_ZERO};
      SLT:    oi = '{FMT_R,   OPC_OP,     3'd2, F7_ZERO};
      SLTU:   oi = '{FMT_R,   OPC_OP,     3'd3, F7_ZERO};
      XOR:    oi = '{FMT_R,   OPC_OP,     3'd4, F7_ZERO};
      SRL:    oi = '{FMT_R,   OPC_OP,     3'd5, F7_ZERO};
      SRA:    oi = '{FMT_R,   OPC_OP,     3'd5, F7_ALT};
      OR:     oi = '{FMT_R,   OPC_OP,     3'd6, F7_ZERO};
      AND:    oi = '{FMT_R,   OPC_OP,     3'd7, F7_ZERO};
      // FENCE fm/pred/succ travel in the 12-bit immediate.
      FENCE:  oi = '{FMT_I,   OPC_FENCE,  3'd0, F7_ZERO};
      // funct7[0] selects the imm[0] bit that distinguishes EBREAK from ECALL.
      ECALL:  oi = '{FMT_SYS, OPC_SYSTEM, 3'd0, 7'd0};
      EBREAK: oi = '{FMT_SYS, OPC_SYSTEM, 3'd0, 7'd1};
      CSRRW:  oi = '{FMT_CSR, OPC_SYSTEM, 3'd1, F7_ZERO};
      CSRRS:  oi = '{FMT_CSR, OPC_SYSTEM, 3'd2, F7_ZERO};
      CSRRC:  oi = '{FMT_CSR, OPC_SYSTEM, 3'd3, F7_ZERO};
      CSRRWI: oi = '{FMT_CSR, OPC_SYSTEM, 3'd5, F7_ZERO};
      CSRRSI: oi = '{FMT_CSR, OPC_SYSTEM, 3'd6, F7_ZERO};
      CSRRCI: oi = '{FMT_CSR, OPC_SYSTEM, 3'd7, F7_ZERO};
      default: ;
    endcase
    return oi;
  endfunction

  // Returns {illegal, word}; illegal items always carry a zero word.
  function automatic logic [WORD_SIZE:0] encode(input logic [6:0] inst, input reg_t rs1,
                                                input reg_t rs2, input reg_t rd, input data_t imm);
    op_info_t oi;
    logic ok;
    data_t w;
    logic i12_ok, b13_ok, j21_ok;
    oi = op_info(inst);
    // Sign-extendable checks: all bits above the top kept bit equal it.
    i12_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
    b13_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
    j21_ok = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];
    ok = 1'b1;
    w = '0;
    case (oi.fmt)
      FMT_R:   w = {oi.funct7, rs2, rs1, oi.funct3, rd, oi.opcode};
      FMT_I:   begin ok = i12_ok; w = {imm[11:0], rs1, oi.funct3, rd, oi.opcode}; end
      FMT_SH:  begin ok = (imm[31:5] == '0); w = {oi.funct7, imm[4:0], rs1, oi.funct3, rd, oi.opcode}; end
      FMT_S:   begin ok = i12_ok; w = {imm[11:5], rs2, rs1, oi.funct3, imm[4:0], oi.opcode}; end
      FMT_B:   begin
        ok = b13_ok;
        w = {imm[12], imm[10:5], rs2, rs1, oi.funct3, imm[4:1], imm[11], oi.opcode};
      end
      FMT_U:   begin ok = (imm[11:0] == '0); w = {imm[31:12], rd, oi.opcode}; end
      FMT_J:   begin ok = j21_ok; w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, oi.opcode}; end
      // rs1 doubles as zimm for the immediate CSR forms; layout is identical.
      FMT_CSR: begin ok = (imm[31:12] == '0); w = {imm[11:0], rs1, oi.funct3, rd, oi.opcode}; end
      FMT_SYS: w = {11'd0, oi.funct7[0], 13'd0, oi.opcode};
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, w} : {1'b1, {WORD_SIZE{1'b0}}};
  endfunction

endpackage

// File: rtl/inst_item_encoder_sync_fifo.sv
// Generic single-clock FIFO with an extra pointer bit to tell full from empty.
// Latency: a pushed entry is visible at the head one cycle later; no bypass.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; DEPTH is a power of two so natural wrap is correct.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/inst_item_encoder.sv
// Encodes instruction items into RV32I words and queues them with an illegal flag.
// Latency: one cycle from acceptance to out_valid when the queue is empty.
// Backpressure: in_ready drops when the queue is full; out side is valid/ready.
module inst_item_encoder
  import inst_item_encoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_instruction,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [4:0]           in_rd,
  input  logic [WORD_SIZE-1:0] in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_word,
  output logic                 out_illegal,
  output logic [CNT_W-1:0]     enc_count,
  output logic [CNT_W-1:0]     illegal_count
);
  logic [WORD_SIZE:0] enc_dat, head_dat;
  logic               full, empty, push, pop;

  assign enc_dat   = encode(in_instruction, in_rs1, in_rs2, in_rd, in_imm);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // Zero the outputs while empty so stale storage never leaks out.
  assign out_word    = empty ? '0 : head_dat[WORD_SIZE-1:0];
  assign out_illegal = !empty && head_dat[WORD_SIZE];

  sync_fifo #(.WIDTH(WORD_SIZE + 1), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (enc_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (full),
    .empty    (empty)
  );

  // Statistics count output handshakes and wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_count     <= '0;
      illegal_count <= '0;
    end else if (pop) begin
      enc_count <= enc_count + 1'b1;
      if (out_illegal) illegal_count <= illegal_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_inst_item_encoder.sv
// Randomized + directed bench for the instruction item encoder.
// Latency: model mirrors queue occupancy cycle by cycle.
// Backpressure: out_ready toggled randomly and held low in a dedicated phase.
module tb_inst_item_encoder;
  import inst_item_encoder_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0, in_ready;
  logic [6:0]  in_instruction = 0;
  logic [4:0]  in_rs1 = 0, in_rs2 = 0, in_rd = 0;
  logic [31:0] in_imm = 0;
  logic        out_valid, out_ready = 0;
  logic [31:0] out_word;
  logic        out_illegal;
  logic [CNT_W-1:0] enc_count, illegal_count;

  int vectors = 0;
  int miscompares = 0;

  inst_item_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_illegal(out_illegal), .enc_count(enc_count), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder from the ISA field definitions using integer arithmetic.
  function automatic logic [32:0] ref_encode(input int inst, input int rs1, input int rs2,
                                             input int rd, input logic [31:0] imm);
    int s, op, f3, f7;
    byte fmt;
    logic [31:0] u, w;
    bit ok;
    s = $signed(imm);
    u = imm;
    fmt = "-"; op = 0; f3 = 0; f7 = 0;
    case (inst)
      1:  begin fmt = "U"; op = 'h37; end
      2:  begin fmt = "U"; op = 'h17; end
      3:  begin fmt = "J"; op = 'h6F; end
      4:  begin fmt = "I"; op = 'h67; end
      5, 6, 7, 8, 9, 10: begin
        fmt = "B"; op = 'h63;
        f3 = (inst <= 6) ? inst - 5 : inst - 3;  // BEQ0 BNE1 BLT4 BGE5 BLTU6 BGEU7
      end
      11: begin fmt = "I"; op = 'h03; f3 = 0; end
      12: begin fmt = "I"; op = 'h03; f3 = 1; end
      13: begin fmt = "I"; op = 'h03; f3 = 2; end
      14: begin fmt = "I"; op = 'h03; f3 = 4; end
      15: begin fmt = "I"; op = 'h03; f3 = 5; end
      16, 17, 18: begin fmt = "S"; op = 'h23; f3 = inst - 16; end
      19: begin fmt = "I"; op = 'h13; f3 = 0; end
      20: begin fmt = "I"; op = 'h13; f3 = 2; end
      21: begin fmt = "I"; op = 'h13; f3 = 3; end
      22: begin fmt = "I"; op = 'h13; f3 = 4; end
      23: begin fmt = "I"; op = 'h13; f3 = 6; end
      24: begin fmt = "I"; op = 'h13; f3 = 7; end
      25: begin fmt = "H"; op = 'h13; f3 = 1; end
      26: begin fmt = "H"; op = 'h13; f3 = 5; end
      27: begin fmt = "H"; op = 'h13; f3 = 5; f7 = 32; end
      28: begin fmt = "R"; op = 'h33; f3 = 0; end
      29: begin fmt = "R"; op = 'h33; f3 = 0; f7 = 32; end
      30, 31, 32, 33, 34: begin fmt = "R"; op = 'h33; f3 = inst - 29; end
      35: begin fmt = "R"; op = 'h33; f3 = 5; f7 = 32; end
      36: begin fmt = "R"; op = 'h33; f3 = 6; end
      37: begin fmt = "R"; op = 'h33; f3 = 7; end
      38: begin fmt = "I"; op = 'h0F; end
      39: begin fmt = "Y"; op = 'h73; end
      40: begin fmt = "Y"; op = 'h73; f7 = 1; end
      41, 42, 43: begin fmt = "C"; op = 'h73; f3 = inst - 40; end
      44, 45, 46: begin fmt = "C"; op = 'h73; f3 = inst - 39; end
      default: fmt = "-";
    endcase
    ok = 1; w = 0;
    case (fmt)
      "R": w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      "I": begin ok = (s >= -2048 && s <= 2047);
                 w = ((u & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op; end
      "H": begin ok = (u < 32); w = (f7 << 25) | (u << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op; end
      "S": begin ok = (s >= -2048 && s <= 2047);
                 w = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                     | ((u & 'h1F) << 7) | op; end
      "B": begin ok = (s >= -4096 && s <= 4095 && (s % 2) == 0);
                 w = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
                     | (f3 << 12) | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | op; end
      "U": begin ok = ((u % 4096) == 0); w = u + (rd << 7) + op; end
      "J": begin ok = (s >= -1048576 && s <= 1048575 && (s % 2) == 0);
                 w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20)
                     | (((u >> 12) & 'hFF) << 12) | (rd << 7) | op; end
      "C": begin ok = (u < 4096); w = (u << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op; end
      "Y": w = (f7 << 20) | op;
      default: ok = 0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'd0};
  endfunction

  // Queue-level model of the encoder: contents, counters, sync state.
  logic [32:0]      exp_q[$];
  logic [CNT_W-1:0] m_enc = 0, m_ill = 0;
  bit               synced = 0;

  // Compare against the model, then advance it to what the next edge will do.
  always @(negedge clk) begin
    bit do_push, do_pop;
    if (synced) begin
      chk("in_ready", in_ready, exp_q.size() < DEPTH);
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("out_word", out_word, exp_q[0][31:0]);
        chk("out_illegal", out_illegal, exp_q[0][32]);
      end else begin
        chk("out_word_idle", out_word, 0);
        chk("out_illegal_idle", out_illegal, 0);
      end
      chk("enc_count", enc_count, m_enc);
      chk("illegal_count", illegal_count, m_ill);
    end
    if (rst) begin
      exp_q.delete();
      m_enc = 0; m_ill = 0;
      synced = 1;
    end else if (synced) begin
      do_push = in_valid && (exp_q.size() < DEPTH);
      do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop) begin
        m_enc++;
        if (exp_q[0][32]) m_ill++;
        void'(exp_q.pop_front());
      end
      if (do_push) exp_q.push_back(ref_encode(in_instruction, in_rs1, in_rs2, in_rd, in_imm));
    end
  end

  task automatic set_item(input int inst, input int rs1, input int rs2, input int rd, input logic [31:0] imm);
    in_instruction = inst[6:0]; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0]; in_rd = rd[4:0]; in_imm = imm;
  endtask

  // Present one item and hold it until accepted, with a bounded wait.
  task automatic push_one(input int inst, input int rs1, input int rs2, input int rd, input logic [31:0] imm);
    set_item(inst, rs1, rs2, rd, imm);
    in_valid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("push_timeout", 1, 0);
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; in_valid = 0;
    idle(2);
    rst = 0;
  endtask

  int bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 31, 32, 1048574, -1048576};

  initial begin
    logic [CNT_W-1:0] ill0;
    int sel;
    // Pin the reference encoder with hand-computed words.
    chk("ref_addi",  ref_encode(ADDI, 0, 0, 1, 5),           {1'b0, 32'h00500093});
    chk("ref_add",   ref_encode(ADD, 1, 2, 3, 0),            {1'b0, 32'h002081B3});
    chk("ref_sw",    ref_encode(SW, 1, 2, 0, 8),             {1'b0, 32'h0020A423});
    chk("ref_beq",   ref_encode(BEQ, 1, 2, 0, -4),           {1'b0, 32'hFE208EE3});
    chk("ref_jal",   ref_encode(JAL, 0, 0, 1, 32'h800),      {1'b0, 32'h001000EF});
    chk("ref_lui",   ref_encode(LUI, 0, 0, 5, 32'h12345000), {1'b0, 32'h123452B7});
    chk("ref_addi_ill", ref_encode(ADDI, 0, 0, 1, 2048),     {1'b1, 32'h0});
    chk("ref_beq_odd",  ref_encode(BEQ, 1, 2, 0, 3),         {1'b1, 32'h0});

    do_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_enc_count", enc_count, 0);
    @(posedge clk); #1;

    // Directed: ADDI visible one cycle after acceptance.
    out_ready = 0;
    push_one(ADDI, 0, 0, 1, 5);
    @(negedge clk);
    chk("addi_word", out_word, 32'h00500093);
    chk("addi_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1;
    idle(2);
    push_one(ADD, 1, 2, 3, 0);
    push_one(SW, 1, 2, 0, 8);
    push_one(BEQ, 1, 2, 0, -4);
    push_one(JAL, 0, 0, 1, 32'h800);
    push_one(LUI, 0, 0, 5, 32'h12345000);
    idle(3);
    ill0 = illegal_count;
    push_one(ADDI, 0, 0, 1, 2048);
    push_one(BEQ, 1, 2, 0, 3);
    idle(3);
    @(negedge clk);
    chk("illegal_delta", illegal_count - ill0, 2);
    @(posedge clk); #1;

    // Backpressure: hold five items against a stalled consumer, then drain.
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      set_item(ADDI, k, 0, k + 1, k * 3);
      in_valid = 1;
      @(negedge clk);
      if (k == 4) chk("bp_full", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    idle(2);
    out_ready = 1;
    idle(8);

    // Reset with three words queued.
    out_ready = 0;
    for (int k = 0; k < 3; k++) push_one(ORI, k, 0, k, 7);
    do_reset();
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_count", enc_count, 0);
    chk("rst_mid_ready", in_ready, 1);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 5);
      case (sel)
        0: in_imm = $urandom_range(0, 63);
        1: in_imm = bnd[$urandom_range(0, 11)];
        2: in_imm = $urandom;
        3: in_imm = $urandom & 32'hFFFFF000;
        4: in_imm = -$urandom_range(0, 5000);
        default: in_imm = $urandom_range(0, 2097151) - 1048576;
      endcase
      in_instruction = 7'($urandom_range(0, 55));
      in_rs1 = 5'($urandom); in_rs2 = 5'($urandom); in_rd = 5'($urandom);
      if (c == 2000) rst = 1;
      if (c == 2002) rst = 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
